// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared definitions for the ID issue controller: FSM encoding and width defaults.
package pipe_issue_ctrl_pkg;

  localparam int unsigned REG_AW_DEF       = 5;
  localparam int unsigned CNT_W_DEF        = 2;
  localparam int unsigned MAX_INFLIGHT_DEF = 3;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TAKE  = 2'd2;

endpackage

// File: rtl/pipe_issue_ctrl_reg_scoreboard.sv
// Per-GPR count of in-flight writes; x0 is never tracked and always reads as clear.
module reg_scoreboard
  import pipe_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc_en,
  input  logic [REG_AW-1:0] inc_rd,
  input  logic              dec_en,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic              rs1_used,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs2_used,
  output logic              rs1_pending,
  output logic              rs2_pending
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [CNT_W-1:0] cnt [NREG];

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rst || clr) begin
        cnt[r] <= '0;
      end else if (r != 0) begin
        // A matching inc and dec in one cycle cancel out.
        if (inc_en && inc_rd == REG_AW'(r) && !(dec_en && dec_rd == REG_AW'(r)))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_en && dec_rd == REG_AW'(r) && !(inc_en && inc_rd == REG_AW'(r)))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  assign rs1_pending = rs1_used && (rs1 != '0) && (cnt[rs1] != '0);
  assign rs2_pending = rs2_used && (rs2 != '0) && (cnt[rs2] != '0);

endmodule

// File: rtl/pipe_issue_ctrl.sv
// ID issue gate: RAW stall against the write scoreboard, in-flight window limit,
// and timer-interrupt drain/take sequencing.
module pipe_issue_ctrl
  import pipe_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = REG_AW_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_RegWr,
  input  logic              exu_allow_in,
  output logic              id_issue,
  output logic              id_stall,
  input  logic              wb_commit,
  input  logic              wb_RegWr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  input  logic              intr_req,
  output logic              intr_take,
  output logic [CNT_W-1:0]  inflight_cnt,
  output logic              busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] inflight_q;
  logic             rs1_pending, rs2_pending;
  logic             hazard, window_ok;

  reg_scoreboard #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .clr         (flush),
    .inc_en      (id_issue && id_RegWr),
    .inc_rd      (id_rd),
    .dec_en      (wb_commit && wb_RegWr),
    .dec_rd      (wb_rd),
    .rs1         (id_rs1),
    .rs1_used    (id_rs1_used),
    .rs2         (id_rs2),
    .rs2_used    (id_rs2_used),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending)
  );

  assign hazard    = rs1_pending || rs2_pending;
  // A slot freed by this cycle's commit can be reused by this cycle's issue.
  assign window_ok = (inflight_q < CNT_W'(MAX_INFLIGHT)) || wb_commit;
  assign id_issue  = id_valid && exu_allow_in && !hazard && (state_q == ST_RUN)
                   && !intr_req && !flush && window_ok;
  assign id_stall  = id_valid && !id_issue;

  always_ff @(posedge clk) begin
    if (rst || flush)
      inflight_q <= '0;
    else if (id_issue && !wb_commit)
      inflight_q <= inflight_q + CNT_W'(1);
    else if (wb_commit && !id_issue)
      inflight_q <= inflight_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (intr_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!intr_req)              state_d = ST_RUN;
        else if (inflight_q == '0)  state_d = ST_TAKE;
      end
      ST_TAKE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  assign intr_take    = (state_q == ST_TAKE);
  assign inflight_cnt = inflight_q;
  assign busy         = (state_q != ST_RUN);

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: RAW stall, x0, window limit, interrupt drain/abort, flush, reset.
module tb_pipe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_regwr, exu_allow_in;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_issue, id_stall;
  logic       wb_commit, wb_regwr;
  logic [4:0] wb_rd;
  logic       flush, intr_req, intr_take, busy;
  logic [1:0] inflight_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned take_cnt = 0;

  pipe_issue_ctrl #(
    .REG_AW       (5),
    .MAX_INFLIGHT (3),
    .CNT_W        (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs1_used  (id_rs1_used),
    .id_rs2       (id_rs2),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_RegWr     (id_regwr),
    .exu_allow_in (exu_allow_in),
    .id_issue     (id_issue),
    .id_stall     (id_stall),
    .wb_commit    (wb_commit),
    .wb_RegWr     (wb_regwr),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .intr_req     (intr_req),
    .intr_take    (intr_take),
    .inflight_cnt (inflight_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (intr_take) take_cnt++;

  always @(posedge clk) begin
    if (!rst && !flush && wb_commit && wb_regwr && wb_rd != 5'd0)
      assert (dut.u_sb.cnt[wb_rd] != 2'd0)
        else $error("FAIL sb_underflow rd=%0d", wb_rd);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_regwr = 0; exu_allow_in = 1;
    wb_commit = 0; wb_regwr = 0; wb_rd = 0; flush = 0; intr_req = 0;
  endtask

  task automatic set_id(input logic [4:0] rd, input logic wr, input logic [4:0] rs1, input logic use1);
    id_valid = 1; id_rd = rd; id_regwr = wr; id_rs1 = rs1; id_rs1_used = use1;
  endtask

  task automatic set_wb(input logic c, input logic wr, input logic [4:0] rd);
    wb_commit = c; wb_regwr = wr; wb_rd = rd;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("rst_inflight", 32'(inflight_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_take", 32'(intr_take), 0);
    check("rst_issue", 32'(id_issue), 0);
    check("rst_stall", 32'(id_stall), 0);

    // RAW stall on x5
    set_id(5'd5, 1, 5'd0, 0); #1;
    check("raw_prod_issue", 32'(id_issue), 1);
    tick();
    check("raw_sb5_set", 32'(dut.u_sb.cnt[5]), 1);
    set_id(5'd6, 1, 5'd5, 1); #1;
    check("raw_stall", 32'(id_stall), 1);
    check("raw_no_issue", 32'(id_issue), 0);
    tick();
    set_wb(1, 1, 5'd5); #1;
    check("raw_stall_same_commit", 32'(id_stall), 1);
    tick();
    set_wb(0, 0, 5'd0); #1;
    check("raw_sb5_clear", 32'(dut.u_sb.cnt[5]), 0);
    check("raw_release_issue", 32'(id_issue), 1);
    check("raw_inflight0", 32'(inflight_cnt), 0);
    tick();
    idle();
    set_wb(1, 1, 5'd6);
    tick();
    idle(); #1;
    check("raw_cleanup", 32'(inflight_cnt), 0);

    // x0 never tracked; same-cycle inc/dec on x7
    set_id(5'd0, 1, 5'd0, 0); #1;
    check("x0_issue", 32'(id_issue), 1);
    tick();
    set_id(5'd0, 0, 5'd0, 1); set_wb(1, 0, 5'd0); #1;
    check("x0_read_no_hazard", 32'(id_issue), 1);
    tick();
    check("x0_inflight", 32'(inflight_cnt), 1);
    set_id(5'd7, 1, 5'd0, 0); set_wb(1, 0, 5'd0);
    tick();
    check("x7_sb_set", 32'(dut.u_sb.cnt[7]), 1);
    set_id(5'd7, 1, 5'd0, 0); set_wb(1, 1, 5'd7); #1;
    check("x7_issue_with_commit", 32'(id_issue), 1);
    tick();
    check("x7_sb_unchanged", 32'(dut.u_sb.cnt[7]), 1);
    check("x7_inflight", 32'(inflight_cnt), 1);
    idle(); set_wb(1, 1, 5'd7);
    tick();
    idle(); #1;
    check("x7_sb_clear", 32'(dut.u_sb.cnt[7]), 0);
    check("x7_inflight0", 32'(inflight_cnt), 0);

    // full window
    for (int i = 0; i < 3; i++) begin
      set_id(5'd0, 0, 5'd0, 0); #1;
      check("win_issue", 32'(id_issue), 1);
      tick();
    end
    check("win_full_cnt", 32'(inflight_cnt), 3);
    #1;
    check("win_fourth_stall", 32'(id_stall), 1);
    tick();
    set_wb(1, 0, 5'd0); #1;
    check("win_issue_on_commit", 32'(id_issue), 1);
    tick();
    check("win_cnt_held", 32'(inflight_cnt), 3);
    idle(); set_wb(1, 0, 5'd0);
    tick(); tick(); tick();
    idle(); #1;
    check("win_drained", 32'(inflight_cnt), 0);

    // interrupt drain with two in flight
    set_id(5'd0, 0, 5'd0, 0); tick(); tick();
    check("irq_pre_cnt", 32'(inflight_cnt), 2);
    intr_req = 1; #1;
    check("irq_issue_blocked", 32'(id_issue), 0);
    check("irq_stall", 32'(id_stall), 1);
    tick();
    check("irq_busy", 32'(busy), 1);
    id_valid = 0; set_wb(1, 0, 5'd0);
    tick();
    check("irq_drain1_take", 32'(intr_take), 0);
    tick();
    set_wb(0, 0, 5'd0); #1;
    check("irq_drained_cnt", 32'(inflight_cnt), 0);
    check("irq_drain2_take", 32'(intr_take), 0);
    tick();
    check("irq_take", 32'(intr_take), 1);
    check("irq_take_busy", 32'(busy), 1);
    intr_req = 0;
    tick();
    check("irq_take_done", 32'(intr_take), 0);
    check("irq_back_run", 32'(busy), 0);
    check("irq_take_once", take_cnt, 1);

    // abort during drain
    set_id(5'd0, 0, 5'd0, 0); tick();
    idle(); intr_req = 1;
    tick();
    check("abort_busy", 32'(busy), 1);
    intr_req = 0;
    tick();
    check("abort_run", 32'(busy), 0);
    check("abort_no_take", take_cnt, 1);
    set_wb(1, 0, 5'd0); tick(); idle();

    // flush overrides issue and commit
    set_id(5'd3, 1, 5'd0, 0); tick(); tick();
    check("flush_pre_sb3", 32'(dut.u_sb.cnt[3]), 2);
    check("flush_pre_cnt", 32'(inflight_cnt), 2);
    flush = 1; set_wb(1, 1, 5'd3); #1;
    check("flush_blocks_issue", 32'(id_issue), 0);
    tick();
    idle(); #1;
    check("flush_sb3", 32'(dut.u_sb.cnt[3]), 0);
    check("flush_cnt", 32'(inflight_cnt), 0);
    check("flush_no_take", take_cnt, 1);

    // reset mid-drain
    set_id(5'd9, 1, 5'd0, 0); tick();
    idle(); intr_req = 1;
    tick();
    check("rstd_busy", 32'(busy), 1);
    rst = 1;
    tick();
    rst = 0; intr_req = 0; #1;
    check("rstd_run", 32'(busy), 0);
    check("rstd_cnt", 32'(inflight_cnt), 0);
    check("rstd_sb9", 32'(dut.u_sb.cnt[9]), 0);
    tick();
    check("rstd_no_take", take_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
